// File: rtl/noc_output_arbiter_if.sv
// noc_output_arbiter_if
//   Bundle of the arbiter's handshake and data signals for one output link.
//   master : the side that presents requests/flits and downstream backpressure
//   slave  : the arbiter itself
//   req_in     port i presents a valid flit
//   data_in    flit of port i at [i*BUS_WIDTH +: BUS_WIDTH]
//   buffer_out 1 = port i must hold its flit this cycle
//   buffer_in  1 = downstream full
//   router_out registered output flit, out_valid marks a new one
//   grant      one-hot owner of the current/last transfer
//   locked     mid-packet, err_flit one-cycle protocol error pulse
interface noc_output_arbiter_if #(
    parameter int BUS_WIDTH = 32,
    parameter int NUM_REQ   = 5
);
    logic [NUM_REQ-1:0]           req_in;
    logic [NUM_REQ*BUS_WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]           buffer_out;
    logic                         buffer_in;
    logic [BUS_WIDTH-1:0]         router_out;
    logic                         out_valid;
    logic [NUM_REQ-1:0]           grant;
    logic                         locked;
    logic                         err_flit;

    modport master (
        output req_in, data_in, buffer_in,
        input  buffer_out, router_out, out_valid, grant, locked, err_flit
    );

    modport slave (
        input  req_in, data_in, buffer_in,
        output buffer_out, router_out, out_valid, grant, locked, err_flit
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
//   Packet-aware round-robin arbiter for one router output link. Shares the
//   link among NUM_REQ input ports, registers the winning flit, and locks the
//   link to a port from its head flit until its tail flit.
//   clk1 : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : slave side of noc_output_arbiter_if (requests, flits, stalls,
//          registered output flit, grant, lock and error status)
module noc_output_arbiter #(
    parameter int BUS_WIDTH = 32,
    parameter int NUM_REQ   = 5,
    parameter int PTR_W     = 3
) (
    input  logic                clk1,
    input  logic                rst,
    noc_output_arbiter_if.slave bus
);
    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b01;
    localparam logic [1:0] FT_HEAD   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]     owner, owner_nxt;
    logic [PTR_W-1:0]     sel, sel_inc;
    logic                 sel_vld, accept;
    logic [NUM_REQ-1:0]   sel_oh;
    logic [BUS_WIDTH-1:0] flit;
    logic [1:0]           ftype;
    logic                 fwd, err;

    logic [BUS_WIDTH-1:0] router_out_q;
    logic                 out_valid_q, err_flit_q;
    logic [NUM_REQ-1:0]   grant_q;

    // Port selection. In BUSY only the owner may move. In IDLE the search
    // runs from the largest rotation offset down so the smallest offset from
    // rr_ptr is the one left standing.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        if (state == BUSY) begin
            sel = owner;
            for (int i = 0; i < NUM_REQ; i++)
                if (owner == PTR_W'(i) && bus.req_in[i]) sel_vld = 1'b1;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--)
                for (int i = 0; i < NUM_REQ; i++)
                    if (bus.req_in[i] && ((int'(rr_ptr) + k) % NUM_REQ) == i) begin
                        sel     = PTR_W'(i);
                        sel_vld = 1'b1;
                    end
        end
    end

    always_comb begin
        flit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_oh[i] = (sel == PTR_W'(i));
            if (sel == PTR_W'(i)) flit = bus.data_in[i*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    assign ftype   = flit[BUS_WIDTH-1 -: 2];
    assign accept  = sel_vld && !bus.buffer_in;
    assign sel_inc = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

    // Everyone but an accepted winner holds, including idle ports.
    assign bus.buffer_out = ~(sel_oh & {NUM_REQ{accept}});

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        fwd        = 1'b0;
        err        = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    case (ftype)
                        FT_HEAD: begin
                            fwd       = 1'b1;
                            owner_nxt = sel;
                            state_nxt = BUSY;
                        end
                        FT_SINGLE: begin
                            fwd        = 1'b1;
                            rr_ptr_nxt = sel_inc;
                        end
                        // orphan body/tail: consumed so the port cannot wedge
                        default: err = 1'b1;
                    endcase
                end
                BUSY: begin
                    fwd = 1'b1;
                    if (ftype != FT_BODY) begin
                        // head/single mid-packet closes the packet as if it were the tail
                        rr_ptr_nxt = sel_inc;
                        state_nxt  = IDLE;
                        err        = (ftype != FT_TAIL);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            grant_q      <= '0;
            router_out_q <= '0;
            out_valid_q  <= 1'b0;
            err_flit_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            owner       <= owner_nxt;
            out_valid_q <= fwd;
            err_flit_q  <= err;
            if (fwd) begin
                router_out_q <= flit;
                grant_q      <= sel_oh;
            end
        end
    end

    assign bus.router_out = router_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.grant      = grant_q;
    assign bus.err_flit   = err_flit_q;
    assign bus.locked     = (state == BUSY);
endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter
//   Table-driven, hand-sequenced and random checks of noc_output_arbiter
//   against a port-index/queue-free behavioural model of the arbitration rules.
module tb_noc_output_arbiter;
    localparam int NR = 5;
    localparam int BW = 32;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    noc_output_arbiter_if #(.BUS_WIDTH(BW), .NUM_REQ(NR)) bus ();

    noc_output_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .PTR_W(3)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    typedef logic [NR-1:0][BW-1:0] dat_t;

    typedef struct {
        logic [NR-1:0] req;
        dat_t          dat;
        logic [NR-1:0] bo;
        logic          vld;
        logic [BW-1:0] out;
        logic [NR-1:0] gnt;
        logic          err;
        logic          lck;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model: owner -1 means no packet in progress
    int            m_owner;
    int            m_ptr;
    logic [BW-1:0] m_out;
    logic [NR-1:0] m_grant;
    logic          m_vld, m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_out = '0; m_grant = '0; m_vld = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [NR-1:0] req, input dat_t dat, input logic bin,
                              output logic [NR-1:0] ebo);
        int s;
        logic [1:0] t;
        s = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < NR; k++)
                if (s < 0 && req[(m_ptr + k) % NR]) s = (m_ptr + k) % NR;
        end else if (req[m_owner]) s = m_owner;
        ebo = '1;
        m_vld = 0;
        m_err = 0;
        if (s >= 0 && !bin) begin
            ebo[s] = 1'b0;
            t = dat[s][BW-1 -: 2];
            if (m_owner < 0) begin
                if (t[1]) begin
                    m_vld = 1; m_out = dat[s]; m_grant = '0; m_grant[s] = 1'b1;
                    if (t == 2'b10) m_owner = s;
                    else m_ptr = (s + 1) % NR;
                end else m_err = 1;
            end else begin
                m_vld = 1; m_out = dat[s];
                if (t != 2'b00) begin
                    m_ptr = (s + 1) % NR;
                    m_owner = -1;
                    m_err = t[1];
                end
            end
        end
    endtask

    // Drive at the falling edge, check stalls mid-low-phase, check registered
    // outputs 1 time unit after the rising edge, return at the next falling edge.
    task automatic drive_cycle(input logic [NR-1:0] req, input dat_t dat, input logic bin,
                               output logic [NR-1:0] bo_seen);
        logic [NR-1:0] ebo;
        bus.req_in = req;
        bus.data_in = dat;
        bus.buffer_in = bin;
        #2;
        bo_seen = bus.buffer_out;
        model_step(req, dat, bin, ebo);
        chk("buffer_out", bo_seen, ebo);
        @(posedge clk1);
        #1;
        chk("out_valid", bus.out_valid, m_vld);
        chk("err_flit", bus.err_flit, m_err);
        chk("grant", bus.grant, m_grant);
        chk("locked", bus.locked, m_owner >= 0);
        chk("router_out", bus.router_out, m_out);
        @(negedge clk1);
    endtask

    function automatic vec_t mk(input logic [NR-1:0] req, input dat_t dat, input logic [NR-1:0] bo,
                                input logic vld, input logic [BW-1:0] out, input logic [NR-1:0] gnt,
                                input logic err, input logic lck);
        vec_t v;
        v.req = req; v.dat = dat; v.bo = bo; v.vld = vld; v.out = out;
        v.gnt = gnt; v.err = err; v.lck = lck;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        dat_t          fair, d;
        logic [NR-1:0] bo;
        int            cnt;

        bus.req_in = '0;
        bus.data_in = '0;
        bus.buffer_in = 1'b0;
        model_reset();

        // reset state
        #3;
        chk("rst_router_out", bus.router_out, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_err_flit", bus.err_flit, 0);
        @(negedge clk1);
        rst = 1'b0;

        // fairness, orphan drop, packet lock
        for (int i = 0; i < NR; i++) fair[i] = 32'hC000_0000 | 32'(i);
        tbl[0] = mk(5'b11111, fair, 5'b11110, 1, 32'hC000_0000, 5'b00001, 0, 0);
        tbl[1] = mk(5'b11111, fair, 5'b11101, 1, 32'hC000_0001, 5'b00010, 0, 0);
        tbl[2] = mk(5'b11111, fair, 5'b11011, 1, 32'hC000_0002, 5'b00100, 0, 0);
        tbl[3] = mk(5'b11111, fair, 5'b10111, 1, 32'hC000_0003, 5'b01000, 0, 0);
        tbl[4] = mk(5'b11111, fair, 5'b01111, 1, 32'hC000_0004, 5'b10000, 0, 0);
        tbl[5] = mk(5'b11111, fair, 5'b11110, 1, 32'hC000_0000, 5'b00001, 0, 0);
        d = '0; d[2] = 32'h0000_0055;
        tbl[6] = mk(5'b00100, d, 5'b11011, 0, 32'hC000_0000, 5'b00001, 1, 0);
        d = '0; d[1] = 32'h8000_0011; d[3] = 32'hC000_0003;
        tbl[7] = mk(5'b01010, d, 5'b11101, 1, 32'h8000_0011, 5'b00010, 0, 1);
        d[1] = 32'h0000_0022;
        tbl[8] = mk(5'b01010, d, 5'b11101, 1, 32'h0000_0022, 5'b00010, 0, 1);
        d[1] = 32'h4000_0033;
        tbl[9] = mk(5'b01010, d, 5'b11101, 1, 32'h4000_0033, 5'b00010, 0, 0);
        tbl[10] = mk(5'b01000, d, 5'b10111, 1, 32'hC000_0003, 5'b01000, 0, 0);

        for (int r = 0; r < 11; r++) begin
            drive_cycle(tbl[r].req, tbl[r].dat, 1'b0, bo);
            chk($sformatf("tbl%0d_bo", r), bo, tbl[r].bo);
            chk($sformatf("tbl%0d_vld", r), bus.out_valid, tbl[r].vld);
            chk($sformatf("tbl%0d_out", r), bus.router_out, tbl[r].out);
            chk($sformatf("tbl%0d_gnt", r), bus.grant, tbl[r].gnt);
            chk($sformatf("tbl%0d_err", r), bus.err_flit, tbl[r].err);
            chk($sformatf("tbl%0d_lck", r), bus.locked, tbl[r].lck);
        end

        // backpressure mid-packet: 3 stalled cycles, then the packet resumes
        cnt = 0;
        d = '0; d[2] = 32'h8000_0A00;
        drive_cycle(5'b00100, d, 0, bo); cnt += int'(bus.out_valid);
        d[2] = 32'h0000_0A01;
        drive_cycle(5'b00100, d, 0, bo); cnt += int'(bus.out_valid);
        d[2] = 32'h0000_0A02;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(5'b00101, d, 1, bo);
            chk("t4_stall_bo", bo, 5'b11111);
            chk("t4_stall_vld", bus.out_valid, 0);
        end
        drive_cycle(5'b00100, d, 0, bo); cnt += int'(bus.out_valid);
        chk("t4_resume", bus.router_out, 32'h0000_0A02);
        d[2] = 32'h4000_0A03;
        drive_cycle(5'b00100, d, 0, bo); cnt += int'(bus.out_valid);
        chk("t4_flits", cnt, 4);

        // owner gap: port 0 locked, drops its request while port 4 waits
        d = '0; d[0] = 32'h8000_0B00; d[4] = 32'hC000_0B04;
        drive_cycle(5'b00001, d, 0, bo);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(5'b10000, d, 0, bo);
            chk("t6_gap_bo", bo, 5'b11111);
            chk("t6_gap_lck", bus.locked, 1);
        end
        d[0] = 32'h4000_0B01;
        drive_cycle(5'b10001, d, 0, bo);
        chk("t6_tail", bus.router_out, 32'h4000_0B01);
        drive_cycle(5'b10000, d, 0, bo);
        chk("t6_next_gnt", bus.grant, 5'b10000);

        // asynchronous reset in the middle of a packet
        d = '0; d[1] = 32'h8000_0C00; d[3] = 32'hC000_0C03;
        drive_cycle(5'b00010, d, 0, bo);
        d[1] = 32'h0000_0C01;
        drive_cycle(5'b00010, d, 0, bo);
        #2 rst = 1'b1;
        #1;
        chk("t1_locked", bus.locked, 0);
        chk("t1_out_valid", bus.out_valid, 0);
        chk("t1_grant", bus.grant, 0);
        chk("t1_router_out", bus.router_out, 0);
        model_reset();
        @(negedge clk1);
        rst = 1'b0;
        drive_cycle(5'b11111, fair, 0, bo);
        chk("t1_rearb_gnt", bus.grant, 5'b00001);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [NR-1:0] rq;
            logic          bi;
            rq = NR'($urandom);
            bi = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NR; i++)
                d[i] = {2'($urandom_range(0, 3)), 30'($urandom)};
            drive_cycle(rq, d, bi, bo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
